// File: rtl/tx_frame_arbiter.sv
// Round-robin whole-packet arbiter sharing one MAC transmit FIFO write port
// between two sources, with max-length truncation and a forced inter-packet gap.
module tx_frame_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WORDS = 384,
    parameter int unsigned IPG_CYC   = 4,
    parameter int unsigned CNT_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_vld,
    input  logic              i_a_sop,
    input  logic              i_a_eop,
    output logic              o_a_rdy,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_vld,
    input  logic              i_b_sop,
    input  logic              i_b_eop,
    output logic              o_b_rdy,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_vld,
    output logic              o_tx_sop,
    output logic              o_tx_eop,
    input  logic              i_tx_rdy,
    output logic [1:0]        o_grant,
    output logic              o_err_trunc,
    output logic              o_err_sop
);

    localparam int unsigned GAP_LAST = (IPG_CYC > 0) ? IPG_CYC - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_b_q, last_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               a_rdy, b_rdy, tx_vld, tx_sop, tx_eop, err_trunc, err_sop;
    logic [DATA_W-1:0]  tx_data;
    logic               g_vld, g_eop, at_last, pkt_done;
    logic [DATA_W-1:0]  g_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_b_d  = last_b_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        tx_vld    = 1'b0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        tx_data   = '0;
        err_trunc = 1'b0;
        err_sop   = 1'b0;
        pkt_done  = 1'b0;

        g_vld   = grant_q[1] ? i_b_vld  : i_a_vld;
        g_eop   = grant_q[1] ? i_b_eop  : i_a_eop;
        g_data  = grant_q[1] ? i_b_data : i_a_data;
        at_last = (cnt_q == CNT_W'(MAX_WORDS - 1));

        case (state_q)
            IDLE: begin
                // A wins a tie only when B owned the previous packet.
                if (i_a_vld && i_a_sop && !(i_b_vld && i_b_sop && !last_b_q)) begin
                    grant_d = 2'b01;
                    state_d = SEND;
                end else if (i_b_vld && i_b_sop) begin
                    grant_d = 2'b10;
                    state_d = SEND;
                end
                a_rdy   = i_a_vld & ~i_a_sop;
                b_rdy   = i_b_vld & ~i_b_sop;
                err_sop = a_rdy | b_rdy;
            end
            SEND: begin
                tx_vld  = g_vld;
                tx_data = g_vld ? g_data : '0;
                tx_sop  = g_vld & (cnt_q == '0);
                tx_eop  = g_vld & (g_eop | at_last);
                a_rdy   = grant_q[0] & i_tx_rdy;
                b_rdy   = grant_q[1] & i_tx_rdy;
                if (g_vld && i_tx_rdy) begin
                    if (g_eop) begin
                        pkt_done = 1'b1;
                    end else if (at_last) begin
                        err_trunc = 1'b1;
                        cnt_d     = '0;
                        state_d   = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                a_rdy    = grant_q[0];
                b_rdy    = grant_q[1];
                pkt_done = g_vld & g_eop;
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pkt_done) begin
            cnt_d    = '0;
            gap_d    = '0;
            last_b_d = grant_q[1];
            grant_d  = '0;
            state_d  = (IPG_CYC > 0) ? GAP : IDLE;
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign o_a_rdy     = a_rdy & ~reset;
    assign o_b_rdy     = b_rdy & ~reset;
    assign o_tx_vld    = tx_vld & ~reset;
    assign o_tx_sop    = tx_sop & ~reset;
    assign o_tx_eop    = tx_eop & ~reset;
    assign o_tx_data   = reset ? '0 : tx_data;
    assign o_err_trunc = err_trunc & ~reset;
    assign o_err_sop   = err_sop & ~reset;
    assign o_grant     = grant_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed cycle-by-cycle bench for tx_frame_arbiter (MAX_WORDS = 8, IPG_CYC = 4).
module tb_tx_frame_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] a_data, b_data, tx_data;
    logic        a_vld, a_sop, a_eop, a_rdy;
    logic        b_vld, b_sop, b_eop, b_rdy;
    logic        tx_vld, tx_sop, tx_eop, tx_rdy;
    logic [1:0]  grant;
    logic        err_trunc, err_sop;
    logic [40:0] obs;

    int checks = 0;
    int errors = 0;

    tx_frame_arbiter #(
        .DATA_W   (32),
        .MAX_WORDS(8),
        .IPG_CYC  (4),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_a_data   (a_data),
        .i_a_vld    (a_vld),
        .i_a_sop    (a_sop),
        .i_a_eop    (a_eop),
        .o_a_rdy    (a_rdy),
        .i_b_data   (b_data),
        .i_b_vld    (b_vld),
        .i_b_sop    (b_sop),
        .i_b_eop    (b_eop),
        .o_b_rdy    (b_rdy),
        .o_tx_data  (tx_data),
        .o_tx_vld   (tx_vld),
        .o_tx_sop   (tx_sop),
        .o_tx_eop   (tx_eop),
        .i_tx_rdy   (tx_rdy),
        .o_grant    (grant),
        .o_err_trunc(err_trunc),
        .o_err_sop  (err_sop)
    );

    assign obs = {grant, tx_vld, tx_sop, tx_eop, a_rdy, b_rdy, err_trunc, err_sop, tx_data};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [40:0] pk(input logic [1:0] g, input logic v, input logic s,
                                       input logic e, input logic ar, input logic br,
                                       input logic tr, input logic es, input logic [31:0] d);
        return {g, v, s, e, ar, br, tr, es, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [40:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Inputs were set just after the edge; sample mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [40:0] exp_v);
        #2;
        chk(tag, exp_v);
        tick();
    endtask

    task automatic gap_cycles(input string tag);
        for (int i = 0; i < 4; i++) cyc(tag, '0);
    endtask

    task automatic set_a(input logic v, input logic s, input logic e, input logic [31:0] d);
        a_vld = v; a_sop = s; a_eop = e; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic s, input logic e, input logic [31:0] d);
        b_vld = v; b_sop = s; b_eop = e; b_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        tx_rdy = 1'b1;
        set_a(0, 0, 0, '0);
        set_b(0, 0, 0, '0);
        tick();
        tick();
        // Reset state, with a stray non-sop word presented: everything stays low.
        set_a(1, 0, 0, 32'h99);
        cyc("reset_outputs", '0);
        set_a(0, 0, 0, '0);
        reset = 1'b0;

        // 1: A sends a 4-word packet, then a 1-word packet held through the gap.
        set_a(1, 1, 0, 32'h11);
        cyc("t1_arb", '0);
        cyc("t1_w0", pk(2'b01, 1, 1, 0, 1, 0, 0, 0, 32'h11));
        set_a(1, 0, 0, 32'h12);
        cyc("t1_w1", pk(2'b01, 1, 0, 0, 1, 0, 0, 0, 32'h12));
        set_a(1, 0, 0, 32'h13);
        cyc("t1_w2", pk(2'b01, 1, 0, 0, 1, 0, 0, 0, 32'h13));
        set_a(1, 0, 1, 32'h14);
        cyc("t1_w3", pk(2'b01, 1, 0, 1, 1, 0, 0, 0, 32'h14));
        set_a(1, 1, 1, 32'h21);
        gap_cycles("t1_gap");
        cyc("t1_arb2", '0);
        cyc("t1_single", pk(2'b01, 1, 1, 1, 1, 0, 0, 0, 32'h21));
        set_a(0, 0, 0, '0);
        gap_cycles("t1_gap2");

        // 2: simultaneous requests after reset; A first, then B; then A again.
        do_reset();
        set_a(1, 1, 0, 32'hA1);
        set_b(1, 1, 0, 32'hB1);
        cyc("t2_arb", '0);
        cyc("t2_a0", pk(2'b01, 1, 1, 0, 1, 0, 0, 0, 32'hA1));
        set_a(1, 0, 1, 32'hA2);
        cyc("t2_a1", pk(2'b01, 1, 0, 1, 1, 0, 0, 0, 32'hA2));
        set_a(0, 0, 0, '0);
        gap_cycles("t2_gap");
        cyc("t2_arb_b", '0);
        cyc("t2_b0", pk(2'b10, 1, 1, 0, 0, 1, 0, 0, 32'hB1));
        set_b(1, 0, 1, 32'hB2);
        cyc("t2_b1", pk(2'b10, 1, 0, 1, 0, 1, 0, 0, 32'hB2));
        set_b(0, 0, 0, '0);
        gap_cycles("t2_gap2");
        set_a(1, 1, 1, 32'hC1);
        set_b(1, 1, 1, 32'hD1);
        cyc("t2_arb2", '0);
        cyc("t2_a_again", pk(2'b01, 1, 1, 1, 1, 0, 0, 0, 32'hC1));
        set_a(0, 0, 0, '0);
        gap_cycles("t2_gap3");
        cyc("t2_arb3", '0);
        cyc("t2_b_again", pk(2'b10, 1, 1, 1, 0, 1, 0, 0, 32'hD1));
        set_b(0, 0, 0, '0);
        gap_cycles("t2_gap4");

        // 3: B 3-word packet under MAC back-pressure 1,0,0,1,1.
        set_b(1, 1, 0, 32'h31);
        cyc("t3_arb", '0);
        cyc("t3_w0", pk(2'b10, 1, 1, 0, 0, 1, 0, 0, 32'h31));
        set_b(1, 0, 0, 32'h32);
        tx_rdy = 1'b0;
        cyc("t3_stall0", pk(2'b10, 1, 0, 0, 0, 0, 0, 0, 32'h32));
        cyc("t3_stall1", pk(2'b10, 1, 0, 0, 0, 0, 0, 0, 32'h32));
        tx_rdy = 1'b1;
        cyc("t3_w1", pk(2'b10, 1, 0, 0, 0, 1, 0, 0, 32'h32));
        set_b(1, 0, 1, 32'h33);
        cyc("t3_w2", pk(2'b10, 1, 0, 1, 0, 1, 0, 0, 32'h33));
        set_b(0, 0, 0, '0);
        gap_cycles("t3_gap");

        // 4: A sends 12 words, truncated at 8, remainder drained.
        set_a(1, 1, 0, 32'h41);
        cyc("t4_arb", '0);
        for (int k = 0; k < 8; k++) begin
            set_a(1, k == 0, 0, 32'h41 + k);
            cyc("t4_send", pk(2'b01, 1, k == 0, k == 7, 1, 0, k == 7, 0, 32'h41 + k));
        end
        for (int k = 8; k < 12; k++) begin
            set_a(1, 0, k == 11, 32'h41 + k);
            cyc("t4_drain", pk(2'b01, 0, 0, 0, 1, 0, 0, 0, '0));
        end
        set_a(0, 0, 0, '0);
        gap_cycles("t4_gap");

        // B sends exactly 8 words ending in eop: no truncation.
        set_b(1, 1, 0, 32'h51);
        cyc("t4b_arb", '0);
        for (int k = 0; k < 8; k++) begin
            set_b(1, k == 0, k == 7, 32'h51 + k);
            cyc("t4b_send", pk(2'b10, 1, k == 0, k == 7, 0, 1, 0, 0, 32'h51 + k));
        end
        set_b(0, 0, 0, '0);
        gap_cycles("t4b_gap");

        // 5: non-sop words in IDLE are discarded with a single error pulse.
        set_b(1, 0, 0, 32'h66);
        cyc("t5_b_nosop", pk(2'b00, 0, 0, 0, 0, 1, 0, 1, '0));
        set_b(0, 0, 0, '0);
        cyc("t5_quiet", '0);
        set_a(1, 0, 0, 32'h67);
        set_b(1, 0, 1, 32'h68);
        cyc("t5_both_nosop", pk(2'b00, 0, 0, 0, 1, 1, 0, 1, '0));
        set_a(0, 0, 0, '0);
        set_b(0, 0, 0, '0);
        cyc("t5_quiet2", '0);

        // 6: reset on word 3 of a 6-word A packet, then a fresh packet.
        set_a(1, 1, 0, 32'h71);
        cyc("t6_arb", '0);
        cyc("t6_w0", pk(2'b01, 1, 1, 0, 1, 0, 0, 0, 32'h71));
        set_a(1, 0, 0, 32'h72);
        cyc("t6_w1", pk(2'b01, 1, 0, 0, 1, 0, 0, 0, 32'h72));
        set_a(1, 0, 0, 32'h73);
        #2;
        chk("t6_w2", pk(2'b01, 1, 0, 0, 1, 0, 0, 0, 32'h73));
        reset = 1'b1;
        #1;
        chk("t6_in_reset", '0);
        tick();
        tick();
        reset = 1'b0;
        set_a(1, 1, 1, 32'h81);
        cyc("t6_arb2", '0);
        cyc("t6_new_pkt", pk(2'b01, 1, 1, 1, 1, 0, 0, 0, 32'h81));
        set_a(0, 0, 0, '0);
        gap_cycles("t6_gap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
